// File: rtl/univ_shift_reg_if.sv
// Command/data bundle for the universal shift register.
// Latency: none (wires only); master drives commands, slave returns the register state.
// Backpressure: none; busy/done from the slave tell the master when a command is accepted and finished.
// Build option: USR_PARITY_EN adds the registered parity signal.
// Signals: start/mode/cnt/d/sl_in/sr_in (master -> slave),
//          q/qbar/so_left/so_right/busy/done[/parity] (slave -> master).
interface univ_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             start;
   logic [2:0]       mode;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] d;
   logic             sl_in;
   logic             sr_in;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic             so_left;
   logic             so_right;
   logic             busy;
   logic             done;
`ifdef USR_PARITY_EN
   logic             parity;

   modport master (output start, mode, cnt, d, sl_in, sr_in,
                   input  q, qbar, so_left, so_right, busy, done, parity);
   modport slave  (input  start, mode, cnt, d, sl_in, sr_in,
                   output q, qbar, so_left, so_right, busy, done, parity);
`else
   modport master (output start, mode, cnt, d, sl_in, sr_in,
                   input  q, qbar, so_left, so_right, busy, done);
   modport slave  (input  start, mode, cnt, d, sl_in, sr_in,
                   output q, qbar, so_left, so_right, busy, done);
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: load/clear/hold plus multi-step shl/shr/rol/ror/asr with busy/done.
// Latency: load/clear/hold/cnt=0 finish at the accepting edge; N-step shifts finish N edges after acceptance.
// Backpressure: start is only accepted in IDLE; starts while busy are dropped, done pulses one cycle.
// Build option: define USR_PARITY_EN to add bus.parity (registered ^q, reset 0).
// Ports: clk, rst (sync active-low), bus (univ_shift_reg_if.slave).
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   univ_shift_reg_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [2:0] MODE_HOLD  = 3'b000;
   localparam logic [2:0] MODE_LOAD  = 3'b001;
   localparam logic [2:0] MODE_SHL   = 3'b010;
   localparam logic [2:0] MODE_SHR   = 3'b011;
   localparam logic [2:0] MODE_ROL   = 3'b100;
   localparam logic [2:0] MODE_ROR   = 3'b101;
   localparam logic [2:0] MODE_ASR   = 3'b110;
   localparam logic [2:0] MODE_CLEAR = 3'b111;

   logic [0:0]       state_r;
   logic [2:0]       mode_r;
   logic [CNT_W-1:0] rem;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt;
   logic             busy_r;
   logic             done_r;
   logic             single_op;

   // One step of a shift/rotate; serial inputs are taken live, not latched.
   function automatic logic [WIDTH-1:0] step_op(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic             sl,
                                                input logic             sr);
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         MODE_SHL: r = {v[WIDTH-2:0], sl};
         MODE_SHR: r = {sr, v[WIDTH-1:1]};
         MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
         MODE_ROR: r = {v[0], v[WIDTH-1:1]};
         MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
         default:  r = v;
      endcase
      return r;
   endfunction

   // Commands that complete at the accepting edge without entering RUN.
   assign single_op = (bus.mode == MODE_HOLD) || (bus.mode == MODE_LOAD) ||
                      (bus.mode == MODE_CLEAR);

   // The accepting edge of a shift only arms RUN; the first step happens one edge later.
   always_comb begin
      q_nxt = q_r;
      if (state_r == ST_IDLE) begin
         if (bus.start) begin
            case (bus.mode)
               MODE_LOAD:  q_nxt = bus.d;
               MODE_CLEAR: q_nxt = '0;
               default:    q_nxt = q_r;
            endcase
         end
      end else begin
         q_nxt = step_op(mode_r, q_r, bus.sl_in, bus.sr_in);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         mode_r  <= MODE_HOLD;
         rem     <= '0;
         q_r     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         q_r    <= q_nxt;
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  if (single_op || (bus.cnt == '0)) begin
                     done_r <= 1'b1;
                  end else begin
                     mode_r  <= bus.mode;
                     rem     <= bus.cnt;
                     busy_r  <= 1'b1;
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               rem <= rem - 1'b1;
               if (rem == CNT_W'(1)) begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

`ifdef USR_PARITY_EN
   logic parity_r;

   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_r <= 1'b0;
      end else begin
         parity_r <= ^q_nxt;
      end
   end

   assign bus.parity = parity_r;
`endif

   assign bus.q        = q_r;
   assign bus.qbar     = ~q_r;
   assign bus.so_left  = q_r[WIDTH-1];
   assign bus.so_right = q_r[0];
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
// Expected q values are queued when a command is issued and compared when done pulses.
// Outputs are sampled 1 time unit after each rising edge.
module tb_univ_shift_reg;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_LOAD  = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_SHR   = 3'b011;
   localparam logic [2:0] M_ROL   = 3'b100;
   localparam logic [2:0] M_ROR   = 3'b101;
   localparam logic [2:0] M_ASR   = 3'b110;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [7:0] sb_q[$];
   logic [7:0] step_q[$];

   univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

   univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Continuous invariants.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         checks++;
         if (bus.done === 1'b1 && bus.busy === 1'b1) begin
            failures++;
            $display("FAIL done_busy_overlap done=%b busy=%b (must not both be 1)", bus.done, bus.busy);
         end
`ifdef USR_PARITY_EN
         checks++;
         if (bus.parity !== ^bus.q) begin
            failures++;
            $display("FAIL parity got=%b exp=%b", bus.parity, ^bus.q);
         end
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle start; returns just after the accepting edge.
   task automatic do_cmd(input logic [2:0] m, input logic [3:0] c, input logic [7:0] dv);
      bus.mode  = m;
      bus.cnt   = c;
      bus.d     = dv;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // Checks done before ticking so a done visible right now is seen.
   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (bus.done === 1'b1) ok = 1'b1;
         else tick();
      end
      if (!ok && bus.done === 1'b1) ok = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start = 1'b1; bus.mode = M_LOAD; bus.d = 8'hFF; bus.cnt = 4'd0;
      tick();
      tick();
      checks++;
      if (bus.q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", bus.q); end
      checks++;
      if (bus.qbar !== 8'hFF) begin failures++; $display("FAIL reset_qbar got=%h exp=FF", bus.qbar); end
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", bus.busy, bus.done);
      end
      bus.start = 1'b0;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_load();
      logic [7:0] e;
      sb_q.push_back(8'hA5);
      do_cmd(M_LOAD, 4'd0, 8'hA5);
      checks++;
      if (bus.done !== 1'b1) begin failures++; $display("FAIL load_done got=%b exp=1", bus.done); end
      e = sb_q.pop_front();
      checks++;
      if (bus.q !== e) begin failures++; $display("FAIL load_q got=%h exp=%h", bus.q, e); end
      checks++;
      if (bus.qbar !== 8'h5A) begin failures++; $display("FAIL load_qbar got=%h exp=5A", bus.qbar); end
      checks++;
      if (bus.so_left !== 1'b1 || bus.so_right !== 1'b1) begin
         failures++; $display("FAIL load_so left=%b right=%b exp=1/1", bus.so_left, bus.so_right);
      end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL load_busy got=%b exp=0", bus.busy); end
      tick();
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL load_done_width got=%b exp=0", bus.done); end
   endtask

   task automatic test_shl();
      logic [7:0] e;
      step_q.push_back(8'h4B); step_q.push_back(8'h97); step_q.push_back(8'h2F);
      sb_q.push_back(8'h2F);
      bus.sl_in = 1'b1;
      do_cmd(M_SHL, 4'd3, 8'h00);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.q !== 8'hA5) begin
         failures++;
         $display("FAIL shl_accept busy=%b done=%b q=%h exp=1/0/A5", bus.busy, bus.done, bus.q);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         e = step_q.pop_front();
         checks++;
         if (bus.q !== e) begin failures++; $display("FAIL shl_step%0d got=%h exp=%h", i, bus.q, e); end
         checks++;
         if (bus.busy !== (i < 3) || bus.done !== (i == 3)) begin
            failures++;
            $display("FAIL shl_flags%0d busy=%b done=%b exp=%b/%b", i, bus.busy, bus.done, i < 3, i == 3);
         end
      end
      e = sb_q.pop_front();
      checks++;
      if (bus.q !== e) begin failures++; $display("FAIL shl_final got=%h exp=%h", bus.q, e); end
      tick();
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL shl_done_width got=%b exp=0", bus.done); end
   endtask

   // Runs a load then one shift/rotate and compares q when done pulses.
   task automatic test_rot_asr();
      logic [7:0] e;
      bit ok;
      logic [7:0] init_v[3] = '{8'hA5, 8'h96, 8'h3C};
      logic [2:0] mode_v[3] = '{M_ROR, M_ASR, M_ROL};
      logic [3:0] cnt_v[3]  = '{4'd4, 4'd2, 4'd8};
      logic [7:0] exp_v[3]  = '{8'h5A, 8'hE5, 8'h3C};
      for (int t = 0; t < 3; t++) begin
         do_cmd(M_LOAD, 4'd0, init_v[t]);
         tick();
         sb_q.push_back(exp_v[t]);
         do_cmd(mode_v[t], cnt_v[t], 8'h00);
         if (t == 1) begin
            tick();
            checks++;
            if (bus.q !== 8'hCB) begin failures++; $display("FAIL asr_step1 got=%h exp=CB", bus.q); end
         end
         wait_done(20, ok);
         e = sb_q.pop_front();
         checks++;
         if (!ok) begin failures++; $display("FAIL rot_timeout case=%0d done never seen", t); end
         else if (bus.q !== e) begin failures++; $display("FAIL rot_case%0d got=%h exp=%h", t, bus.q, e); end
         tick();
      end
   endtask

   task automatic test_ignore_start();
      logic [7:0] e;
      bit ok;
      sb_q.push_back(8'h01);
      bus.sr_in = 1'b0;
      do_cmd(M_SHR, 4'd5, 8'h00);
      tick();
      bus.start = 1'b1; bus.mode = M_LOAD; bus.d = 8'h00;
      tick();
      bus.start = 1'b0;
      wait_done(20, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok) begin failures++; $display("FAIL ign_timeout done never seen"); end
      else if (bus.q !== e) begin failures++; $display("FAIL ign_final got=%h exp=%h", bus.q, e); end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.q !== 8'h01) begin
         failures++; $display("FAIL ign_after done=%b q=%h exp=0/01", bus.done, bus.q);
      end
      sb_q.push_back(8'h01);
      do_cmd(M_SHL, 4'd0, 8'h00);
      e = sb_q.pop_front();
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== e) begin
         failures++;
         $display("FAIL cnt0 done=%b busy=%b q=%h exp=1/0/%h", bus.done, bus.busy, bus.q, e);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL cnt0_done_width got=%b exp=0", bus.done); end
   endtask

   task automatic test_reset_abort();
      logic [7:0] e;
      bit ok;
      bit seen;
      do_cmd(M_LOAD, 4'd0, 8'hFF);
      tick();
      bus.sl_in = 1'b0;
      do_cmd(M_SHL, 4'd6, 8'h00);
      tick();
      rst = 1'b0;
      tick();
      checks++;
      if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL abort_state q=%h busy=%b done=%b exp=00/0/0", bus.q, bus.busy, bus.done);
      end
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin failures++; $display("FAIL abort_quiet got=activity exp=no done/busy"); end
      sb_q.push_back(8'h81);
      do_cmd(M_LOAD, 4'd0, 8'h81);
      wait_done(4, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || bus.q !== e) begin
         failures++; $display("FAIL abort_next ok=%b q=%h exp=1/%h", ok, bus.q, e);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      bit ok;
      sb_q.push_back(8'h12);
      do_cmd(M_LOAD, 4'd0, 8'h12);
      e = sb_q.pop_front();
      checks++;
      if (bus.done !== 1'b1 || bus.q !== e) begin
         failures++; $display("FAIL b2b_load done=%b q=%h exp=1/%h", bus.done, bus.q, e);
      end
      // New start accepted in the done cycle.
      sb_q.push_back(8'h24);
      bus.mode = M_ROL; bus.cnt = 4'd1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         failures++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", bus.busy, bus.done);
      end
      tick();
      e = sb_q.pop_front();
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== e) begin
         failures++;
         $display("FAIL b2b_rol done=%b busy=%b q=%h exp=1/0/%h", bus.done, bus.busy, bus.q, e);
      end
      // sr_in is sampled live at each step edge.
      sb_q.push_back(8'h49);
      bus.sr_in = 1'b1;
      do_cmd(M_SHR, 4'd2, 8'h00);
      tick();
      checks++;
      if (bus.q !== 8'h92) begin failures++; $display("FAIL live_sr_step1 got=%h exp=92", bus.q); end
      bus.sr_in = 1'b0;
      wait_done(10, ok);
      e = sb_q.pop_front();
      checks++;
      if (!ok || bus.q !== e) begin
         failures++; $display("FAIL live_sr_final ok=%b q=%h exp=1/%h", ok, bus.q, e);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b0;
      bus.start = 1'b0; bus.mode = M_HOLD; bus.cnt = 4'd0; bus.d = 8'h00;
      bus.sl_in = 1'b0; bus.sr_in = 1'b0;
      test_reset();
      test_load();
      test_shl();
      test_rot_asr();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the single-bit D flip-flop in seqlogic. Holds a WIDTH-bit word with true and complement outputs (q/qbar, as in the DFF). Supports parallel load, clear, logical/arithmetic shifts and rotates. Multi-step shifts are sequenced by an internal step counter, with busy/done handshake. Used as a generic datapath register and serialiser.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of the step-count input; max steps per command = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- mode  input  3  command: 000 hold, 001 load, 010 shl, 011 shr, 100 rol, 101 ror, 110 asr, 111 clear.
- cnt  input  CNT_W  number of steps for shift/rotate modes.
- d  input  WIDTH  parallel load data.
- sl_in  input  1  serial in for shl (enters bit 0).
- sr_in  input  1  serial in for shr (enters bit WIDTH-1).
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  always ~q.
- so_left  output  1  q[WIDTH-1], combinational from q.
- so_right  output  1  q[0], combinational from q.
- busy  output  1  high while a multi-step command runs.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst==0 at a clk edge): q=0, qbar=all ones, busy=0, done=0, rem=0, FSM=IDLE. Overrides everything, including an in-flight command. Aborted command produces no done.
- FSM states: IDLE, RUN.
- IDLE, start=0: q holds, done=0.
- IDLE, start=1, mode load/clear/hold:
  - Op applied at edge k (q=d, q=0 or unchanged respectively).
  - done=1 for the cycle after edge k.
  - Stay in IDLE; busy stays 0.
- IDLE, start=1, shift/rotate mode, cnt=0: q unchanged, done pulse as above, no RUN.
- IDLE, start=1, shift/rotate mode, cnt=N>=1:
  - Edge k: latch mode into mode_r, set rem=N, busy=1, go to RUN. No shift at edge k.
  - Shifts occur at edges k+1..k+N.
- RUN: each edge applies one step of mode_r and decrements rem.
  - On the step where rem==1: go to IDLE, busy=0, done=1 (done visible in the cycle after edge k+N).
- Step operations:
  - shl: q={q[W-2:0],sl_in}.
  - shr: q={sr_in,q[W-1:1]}.
  - rol: {q[W-2:0],q[W-1]}.
  - ror: {q[0],q[W-1:1]}.
  - asr: {q[W-1],q[W-1:1]}.
  - sl_in/sr_in are sampled live at every step edge, not latched.
- start while busy=1 is ignored. mode, cnt and d changes during RUN have no effect.
- done and busy are never high together. done is never high for 2 consecutive cycles unless a new start is accepted in the done cycle (allowed: IDLE accepts start while done=1).
- Rotates by N>=WIDTH wrap naturally (N mod WIDTH net effect). Shifts by N>=WIDTH fully flush with serial-in values.

Optional Feature:
- Macro: USR_PARITY_EN.
- Defined: adds output port parity (1 bit), registered, equal to ^q after every update; reset value 0.
- Undefined: port absent, no parity logic.

Test Plan:
- Hold rst=0 for 2 edges with start=1, mode=001, d=8'hFF -> q=8'h00, qbar=8'hFF, busy=0, done=0.
- Load: start, mode=001, d=8'hA5 -> next cycle q=8'hA5, qbar=8'h5A, so_left=1, so_right=1, done=1 for exactly 1 cycle, busy never 1.
- From q=8'hA5, start mode=010, cnt=3, sl_in=1 -> q steps 8'h4B, 8'h97, 8'h2F at edges k+1..k+3. busy=1 over edges k..k+2. done=1 only in the cycle after edge k+3.
- From q=8'hA5, ror cnt=4 -> q=8'h5A. Then from q=8'h96, asr cnt=2 -> 8'hCB, 8'hE5. Then rol cnt=8 on 8'h3C -> 8'h3C.
- During a shr cnt=5 run, pulse start with mode=001, d=8'h00 -> ignored, run completes normally. Then shl cnt=0 -> q unchanged, single done pulse.
- Assert rst=0 at edge k+2 of a cnt=6 shift -> q=0, busy=0, no done pulse afterwards. Next command accepted normally.
